// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - single-outstanding data-memory responder with byte lanes and load extension
module data_mem_responder #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [4:0]  rsp_rd,
    output logic        rsp_err
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [31:0] BYTE_LIMIT = 32'(DEPTH) << 2;

    state_t state, state_next;

    logic        cap_we;
    logic [1:0]  cap_size;
    logic        cap_unsigned;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;
    logic [4:0]  cap_rd;

    logic [31:0] mem [DEPTH];

    logic [AW-1:0] word_idx;
    logic [1:0]    lane;
    logic          access_err;
    logic [31:0]   rd_word;
    logic [7:0]    rd_byte;
    logic [15:0]   rd_half;
    logic [31:0]   load_data;
    logic [3:0]    byte_en;
    logic [31:0]   wr_data;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_valid) state_next = ACCESS;
            ACCESS:  state_next = RESP;
            RESP:    if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // req_ready is forced low during reset so a request coinciding with reset is never taken
    always_comb begin
        req_ready = (state == IDLE) && !reset;
        rsp_valid = (state == RESP);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cap_we       <= 1'b0;
            cap_size     <= 2'b00;
            cap_unsigned <= 1'b0;
            cap_addr     <= 32'h0;
            cap_wdata    <= 32'h0;
            cap_rd       <= 5'h0;
        end else if (state == IDLE && req_valid) begin
            cap_we       <= req_we;
            cap_size     <= req_size;
            cap_unsigned <= req_unsigned;
            cap_addr     <= req_addr;
            cap_wdata    <= req_wdata;
            cap_rd       <= req_rd;
        end
    end

    always_comb begin
        word_idx   = cap_addr[AW+1:2];
        lane       = cap_addr[1:0];
        access_err = (cap_size == 2'b11)
                   || (cap_size == 2'b01 && cap_addr[0])
                   || (cap_size == 2'b10 && cap_addr[1:0] != 2'b00)
                   || (cap_addr >= BYTE_LIMIT);
    end

    always_comb begin
        rd_word = mem[word_idx];
        rd_byte = rd_word[{lane, 3'b000} +: 8];
        rd_half = rd_word[{lane[1], 4'b0000} +: 16];
        case (cap_size)
            2'b00:   load_data = {{24{~cap_unsigned & rd_byte[7]}}, rd_byte};
            2'b01:   load_data = {{16{~cap_unsigned & rd_half[15]}}, rd_half};
            default: load_data = rd_word;
        endcase
    end

    // Store data is replicated across lanes so each enabled lane picks up the right bits
    always_comb begin
        case (cap_size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{cap_wdata[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{cap_wdata[15:0]}};
            end
            default: begin
                byte_en = 4'b1111;
                wr_data = cap_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset && state == ACCESS && cap_we && !access_err) begin
            for (int i = 0; i < 4; i++) begin
                if (byte_en[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
            end
        end
    end

    // Response registers only load in ACCESS, so they hold while RESP stalls
    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_rdata <= 32'h0;
            rsp_rd    <= 5'h0;
            rsp_err   <= 1'b0;
        end else if (state == ACCESS) begin
            rsp_err   <= access_err;
            rsp_rdata <= (!cap_we && !access_err) ? load_data : 32'h0;
            rsp_rd    <= (!cap_we && !access_err) ? cap_rd : 5'h0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - scoreboard bench for data_mem_responder with byte-array reference model
module tb_data_mem_responder;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        rsp_err;

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(256), .AW(8)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_rd(rsp_rd), .rsp_err(rsp_err)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  rd;
        logic        err;
    } rsp_t;

    int   checks = 0;
    int   errors = 0;
    rsp_t exp_q[$];
    logic [7:0] tm [1024];
    bit   hold = 0;
    logic hold_val = 1'b0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic rsp_t mk(logic [31:0] d, logic [4:0] rd, logic e);
        rsp_t r;
        r.d = d; r.rd = rd; r.err = e;
        return r;
    endfunction

    // Reference: little-endian byte array, 1024 bytes
    function automatic rsp_t model(bit we, logic [1:0] sz, bit uns, logic [31:0] a,
                                   logic [31:0] wd, logic [4:0] rd);
        rsp_t r;
        int n;
        logic [31:0] v;
        r = '0;
        n = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
        if (sz == 2'd3 || (a % n) != 0 || a >= 32'd1024) begin
            r.err = 1'b1;
            return r;
        end
        if (we) begin
            for (int i = 0; i < n; i++) tm[a + i] = wd[8*i +: 8];
            return r;
        end
        v = 32'h0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = tm[a + i];
        if (!uns && v[8*n-1]) for (int i = n; i < 4; i++) v[8*i +: 8] = 8'hFF;
        r.d = v; r.rd = rd;
        return r;
    endfunction

    initial begin
        rsp_t e;
        forever begin
            @(negedge clk);
            if (!reset && rsp_valid === 1'b1 && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_rsp: got %h with no pending request", {rsp_rdata, rsp_rd, rsp_err});
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp", {rsp_rdata, rsp_rd, rsp_err}, e);
                end
            end
        end
    end

    initial begin
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            rsp_ready = hold ? hold_val : ($urandom_range(0, 3) != 0);
        end
    end

    task automatic issue_x(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd,
                           logic [4:0] rd, bit use_c, rsp_t c);
        rsp_t m;
        int t = 0;
        @(negedge clk);
        while (!req_ready && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL req_ready_timeout: got 0 expected 1");
            return;
        end
        m = model(we, sz, uns, a, wd, rd);
        exp_q.push_back(use_c ? c : m);
        req_we = we; req_size = sz; req_unsigned = uns;
        req_addr = a; req_wdata = wd; req_rd = rd;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic issue(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd, logic [4:0] rd);
        issue_x(we, sz, uns, a, wd, rd, 1'b0, '0);
    endtask

    task automatic issue_c(bit we, logic [1:0] sz, bit uns, logic [31:0] a, logic [31:0] wd,
                           logic [4:0] rd, logic [31:0] ed, logic [4:0] erd, logic ee);
        issue_x(we, sz, uns, a, wd, rd, 1'b1, mk(ed, erd, ee));
    endtask

    task automatic drain();
        int t = 0;
        while (exp_q.size() != 0 && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (exp_q.size() != 0) begin
            checks++; errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int t;
        reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
        req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_rd = 5'h0;
        repeat (2) @(negedge clk);
        chk("reset_req_ready", req_ready, 1'b0);
        chk("reset_rsp_valid", rsp_valid, 1'b0);
        chk("reset_rsp_fields", {rsp_rdata, rsp_rd, rsp_err}, 38'h0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_reset_req_ready", req_ready, 1'b1);

        for (int w = 0; w < 256; w++) issue(1'b1, 2'd2, 1'b0, 32'(w * 4), $urandom, 5'($urandom));
        drain();

        issue_c(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, 5'd3, 32'h0, 5'd0, 1'b0);
        issue_c(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd7, 32'hDEADBEEF, 5'd7, 1'b0);
        issue_c(1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 5'd1, 32'hFFFFFFDE, 5'd1, 1'b0);
        issue_c(1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 5'd2, 32'h000000DE, 5'd2, 1'b0);
        issue_c(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, 5'd3, 32'hFFFFDEAD, 5'd3, 1'b0);
        issue_c(1'b0, 2'd1, 1'b1, 32'h10, 32'h0, 5'd4, 32'h0000BEEF, 5'd4, 1'b0);
        issue_c(1'b1, 2'd0, 1'b0, 32'h11, 32'h55, 5'd9, 32'h0, 5'd0, 1'b0);
        issue_c(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd5, 32'hDEAD55EF, 5'd5, 1'b0);
        issue_c(1'b1, 2'd1, 1'b0, 32'h12, 32'h1234, 5'd9, 32'h0, 5'd0, 1'b0);
        issue_c(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd6, 32'h123455EF, 5'd6, 1'b0);
        issue_c(1'b0, 2'd2, 1'b0, 32'h12, 32'h0, 5'd5, 32'h0, 5'd0, 1'b1);
        issue_c(1'b1, 2'd2, 1'b0, 32'h400, 32'hCAFEF00D, 5'd5, 32'h0, 5'd0, 1'b1);
        issue(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 5'd8);
        issue_c(1'b0, 2'd3, 1'b0, 32'h8, 32'h0, 5'd5, 32'h0, 5'd0, 1'b1);
        drain();

        hold = 1; hold_val = 1'b0;
        issue_c(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 5'd9, 32'h123455EF, 5'd9, 1'b0);
        t = 0;
        while (rsp_valid !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        for (int i = 0; i < 5; i++) begin
            chk("hold_rsp", {rsp_valid, rsp_rdata, rsp_rd, req_ready}, {1'b1, 32'h123455EF, 5'd9, 1'b0});
            @(negedge clk);
        end
        hold = 0;
        drain();

        t = 0;
        while (!req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
        req_addr = 32'h20; req_wdata = 32'hAAAA5555; req_rd = 5'd0;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        chk("abort_rsp_valid", rsp_valid, 1'b0);
        chk("abort_req_ready_in_reset", req_ready, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready_after", {req_ready, rsp_valid}, 2'b10);
        issue(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, 5'd11);
        drain();

        for (int k = 0; k < 300; k++) begin
            a = 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 9) == 0) a = $urandom;
            sz = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                else if (sz == 2'd2) a[1:0] = 2'b00;
            end
            issue(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, $urandom, 5'($urandom));
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
